// File: rtl/zyx_write_arbiter.sv
// Round-robin write arbiter that is the sole owner of the shared {z, y, x} bundle.
// Grants one requester at a time, optionally locked for up to MAX_HOLD writes.
module zyx_write_arbiter #(
    parameter int         N_REQ     = 3,
    parameter int         MAX_HOLD  = 4,
    parameter logic [2:0] RESET_ZYX = 3'b000
) (
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_lock,
    input  logic [3*N_REQ-1:0] i_wdata,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_z,
    output logic               o_y,
    output logic               o_x,
    output logic               o_wr_valid,
    output logic               o_busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    owner_reg, owner_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [HW-1:0]    hold_reg, hold_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [2:0]       zyx_reg, zyx_next;
    logic             wr_valid_reg, wr_valid_next;
    logic             busy_reg, busy_next;

    logic [2:0]       wdata_arr [N_REQ];
    logic [N_REQ-1:0] owner_onehot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign wdata_arr[gi]    = i_wdata[3*gi +: 3];
            assign owner_onehot[gi] = (owner_next == IW'(gi));
        end
    endgenerate

    // Round-robin search: rotate requests so the pointer position lands on bit 0.
    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_shift;
    logic [N_REQ-1:0]   req_rot;
    logic [IW:0]        win_off;
    logic [IW:0]        win_sum;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      win_ptr;
    logic               any_req;

    assign req_dbl   = {i_req, i_req};
    assign req_shift = req_dbl >> ptr_reg;
    assign req_rot   = req_shift[N_REQ-1:0];
    assign any_req   = |i_req;

    always_comb begin
        win_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = (IW+1)'(i);
            end
        end
    end

    assign win_sum = {1'b0, ptr_reg} + win_off;
    assign win_idx = (win_sum >= (IW+1)'(N_REQ)) ? IW'(win_sum - (IW+1)'(N_REQ))
                                                 : IW'(win_sum);
    assign win_ptr = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

    logic owner_req;
    logic owner_lock;
    logic last_write;
    logic wr_en;
    logic release_grant;

    assign owner_req     = i_req[owner_reg];
    assign owner_lock    = i_lock[owner_reg];
    assign last_write    = (hold_reg == HW'(MAX_HOLD - 1));
    assign wr_en         = (state_reg == ST_OWNED) && owner_req;
    assign release_grant = (state_reg == ST_OWNED) &&
                           (!owner_req || !owner_lock || last_write);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            hold_reg     <= '0;
            gnt_reg      <= '0;
            zyx_reg      <= RESET_ZYX;
            wr_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            hold_reg     <= hold_next;
            gnt_reg      <= gnt_next;
            zyx_reg      <= zyx_next;
            wr_valid_reg <= wr_valid_next;
            busy_reg     <= busy_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_OWNED;
                    owner_next = win_idx;
                    ptr_next   = win_ptr;
                    hold_next  = '0;
                end
            end
            ST_OWNED: begin
                if (release_grant) begin
                    hold_next = '0;
                    if (any_req) begin
                        owner_next = win_idx;
                        ptr_next   = win_ptr;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (wr_en) begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: values registered next cycle so every output comes from a flop
    always_comb begin
        gnt_next      = '0;
        busy_next     = 1'b0;
        wr_valid_next = wr_en;
        zyx_next      = zyx_reg;
        if (state_next == ST_OWNED) begin
            gnt_next  = owner_onehot;
            busy_next = 1'b1;
        end
        if (wr_en) begin
            zyx_next = wdata_arr[owner_reg];
        end
    end

    assign o_gnt      = gnt_reg;
    assign o_z        = zyx_reg[2];
    assign o_y        = zyx_reg[1];
    assign o_x        = zyx_reg[0];
    assign o_wr_valid = wr_valid_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_zyx_write_arbiter.sv
// Self-checking bench for zyx_write_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a grant/write-count reference model.
module tb_zyx_write_arbiter;

    localparam int         N   = 3;
    localparam int         MH  = 4;
    localparam logic [2:0] RZ  = 3'b000;

    logic           clk;
    logic           srst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [3*N-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           z, y, x;
    logic           wv;
    logic           busy;

    zyx_write_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH),
        .RESET_ZYX(RZ)
    ) dut (
        .i_clk     (clk),
        .i_srst    (srst),
        .i_req     (req),
        .i_lock    (lock),
        .i_wdata   (wdata),
        .o_gnt     (gnt),
        .o_z       (z),
        .o_y       (y),
        .o_x       (x),
        .o_wr_valid(wv),
        .o_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bundle, how many writes this grant has made
    int         m_owner;
    int         m_ptr;
    int         m_writes;
    int         m_last;
    logic [2:0] m_zyx;
    logic       m_wv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_pick(output int who);
        who = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (who < 0 && req[k]) who = k;
        end
        if (who >= 0) m_ptr = (who + 1) % N;
    endtask

    task automatic model_step();
        int  w;
        bit  rel;
        if (srst) begin
            m_owner = -1; m_ptr = 0; m_writes = 0; m_zyx = RZ; m_wv = 1'b0;
        end else if (m_owner < 0) begin
            m_wv = 1'b0;
            if (req != '0) begin
                model_pick(w);
                m_owner = w; m_writes = 0;
            end
        end else begin
            m_wv = req[m_owner];
            if (m_wv) begin
                m_zyx = wdata[3*m_owner +: 3];
                m_writes++;
                m_last = m_owner;
            end
            rel = !req[m_owner] || !lock[m_owner] || (m_writes == MH);
            if (rel) begin
                m_writes = 0;
                if (req != '0) begin
                    model_pick(w);
                    m_owner = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check_eq("gnt",      32'(gnt),        32'(exp_gnt));
        check_eq("zyx",      32'({z, y, x}),  32'(m_zyx));
        check_eq("wr_valid", 32'(wv),         32'(m_wv));
        check_eq("busy",     32'(busy),       32'(m_owner >= 0));
        if (m_wv) $display("write t=%0t owner=%0d zyx=%03b", $time, m_last, m_zyx);
    endtask

    task automatic do_reset(input int cycles);
        srst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            req = N'($urandom);
            tick();
        end
        srst = 1'b0;
    endtask

    logic [N-1:0] s3_gnt [6];
    logic [2:0]   s3_zyx [6];
    logic [N-1:0] s4_gnt [6];

    initial begin
        m_owner = -1; m_ptr = 0; m_writes = 0; m_last = 0; m_zyx = RZ; m_wv = 1'b0;
        srst = 1'b1; req = '0; lock = '0; wdata = '0;
        s3_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        s3_zyx = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        s4_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};

        // Reset with random requests
        do_reset(2);
        check_eq("rst_gnt",  32'(gnt), 32'h0);
        check_eq("rst_zyx",  32'({z, y, x}), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);

        // Single unlocked write from requester 1
        req = 3'b010; lock = 3'b000; wdata = 9'b000_101_000;
        tick();
        check_eq("s2_gnt", 32'(gnt), 32'h2);
        tick();
        check_eq("s2_zyx", 32'({z, y, x}), 32'h5);
        check_eq("s2_wv",  32'(wv), 32'h1);
        req = 3'b000;
        tick();
        check_eq("s2_nowrite", 32'(wv), 32'h0);
        tick();
        check_eq("s2_idle", 32'(gnt), 32'h0);

        // Full contention, unlocked
        do_reset(1);
        req = 3'b111; lock = 3'b000; wdata = 9'b100_010_001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("s3_gnt%0d", i), 32'(gnt), 32'(s3_gnt[i]));
            check_eq($sformatf("s3_zyx%0d", i), 32'({z, y, x}), 32'(s3_zyx[i]));
        end

        // Lock bound, then reset in the middle of a locked burst
        do_reset(1);
        req = 3'b101; lock = 3'b001; wdata = 9'b100_000_111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("s4_gnt%0d", i), 32'(gnt), 32'(s4_gnt[i]));
        end
        tick();
        check_eq("s6_pre_zyx", 32'({z, y, x}), 32'h7);
        srst = 1'b1;
        tick();
        check_eq("s6_gnt", 32'(gnt), 32'h0);
        check_eq("s6_zyx", 32'({z, y, x}), 32'h0);
        srst = 1'b0; req = 3'b110;
        tick();
        check_eq("s6_ptr0", 32'(gnt), 32'h2);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            srst  = ($urandom_range(0, 63) == 0);
            req   = '0;
            for (int k = 0; k < N; k++) req[k] = ($urandom_range(0, 9) < 6);
            lock  = '0;
            for (int k = 0; k < N; k++) lock[k] = ($urandom_range(0, 9) < 6);
            wdata = 9'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
